// File: rtl/clk_rst_gen.sv
// clk_rst_gen: divided processor/dmem clocks and stretched reset; CLK_GEN_STALL_EN adds a stall input
module clk_rst_gen #(
   parameter int PROC_DIV        = 4,
   parameter int DMEM_DIV        = 2,
   parameter int RST_HOLD_CYCLES = 8
) (
   input  logic clock,
   input  logic reset,
`ifdef CLK_GEN_STALL_EN
   input  logic stall,
`endif
   output logic imem_clock,
   output logic dmem_clock,
   output logic processor_clock,
   output logic regfile_clock,
   output logic sys_reset,
   output logic locked,
   output logic proc_tick
);
   localparam int PW = $clog2(PROC_DIV);
   localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
   localparam logic [PW-1:0] RISE_PH  = PW'(PROC_DIV / 2 - 1);
   localparam logic [PW-1:0] FALL_PH  = PW'(PROC_DIV - 1);
   localparam logic [PW-1:0] DMASK    = PW'(DMEM_DIV / 2 - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD_CYCLES);

   typedef enum logic {HOLD, RUN} state_t;

   state_t        state;
   logic [PW-1:0] ph;
   logic [PW-1:0] ph_nx;
   logic [HW-1:0] hold_cnt;
   logic          rise_ph;
   logic          fall_ph;
   logic          skip;
   logic          rise_ok;
   logic          dmem_tog;

`ifdef CLK_GEN_STALL_EN
   assign skip = stall && (state == RUN);
`else
   assign skip = 1'b0;
`endif

   assign ph_nx         = ph + PW'(1);
   assign rise_ph       = ph == RISE_PH;
   assign fall_ph       = ph == FALL_PH;
   assign rise_ok       = rise_ph && !skip;
   assign dmem_tog      = (ph_nx & DMASK) == '0;
   assign proc_tick     = rise_ok && !reset;
   assign imem_clock    = clock;
   assign regfile_clock = processor_clock;

   // phase counter, divided clocks and the reset-stretch FSM share one register stage
   always_ff @(posedge clock) begin
      if (reset) begin
         ph              <= '0;
         hold_cnt        <= '0;
         state           <= HOLD;
         processor_clock <= 1'b0;
         dmem_clock      <= 1'b0;
         sys_reset       <= 1'b1;
         locked          <= 1'b0;
      end else begin
         ph <= ph_nx;
         if (dmem_tog)
            dmem_clock <= ~dmem_clock;
         if (rise_ok)
            processor_clock <= 1'b1;
         else if (fall_ph)
            processor_clock <= 1'b0;
         if (state == HOLD) begin
            if (rise_ok && hold_cnt != HOLD_MAX)
               hold_cnt <= hold_cnt + HW'(1);
            if (fall_ph && hold_cnt == HOLD_MAX) begin
               sys_reset <= 1'b0;
               locked    <= 1'b1;
               state     <= RUN;
            end
         end
      end
   end
endmodule

// File: tb/tb_clk_rst_gen.sv
// tb_clk_rst_gen: scoreboard bench for default and (8,4,2) clk_rst_gen instances
module tb_clk_rst_gen;
   localparam int E = 95;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic stall = 1'b0;
   logic stall1 = 1'b0;
   logic done = 1'b0;
   logic fin = 1'b0;
   logic im0, dm0, pc0, rf0, sr0, lk0, tk0;
   logic im1, dm1, pc1, rf1, sr1, lk1, tk1;
   logic pv0 = 1'b0;
   logic pv1 = 1'b0;
   int   rises0 = 0;
   int   rises1 = 0;
   int   checks = 0;
   int   errors = 0;
   int   pd [2] = '{4, 8};
   int   dd [2] = '{2, 4};
   int   hc [2] = '{8, 2};

   typedef struct {
      int         e;
      logic [6:0] x0;
      logic [6:0] x1;
   } exp_t;

   exp_t q [$];

   clk_rst_gen u0 (
      .clock(clock), .reset(reset),
`ifdef CLK_GEN_STALL_EN
      .stall(stall),
`endif
      .imem_clock(im0), .dmem_clock(dm0), .processor_clock(pc0), .regfile_clock(rf0),
      .sys_reset(sr0), .locked(lk0), .proc_tick(tk0)
   );

   clk_rst_gen #(.PROC_DIV(8), .DMEM_DIV(4), .RST_HOLD_CYCLES(2)) u1 (
      .clock(clock), .reset(reset),
`ifdef CLK_GEN_STALL_EN
      .stall(stall1),
`endif
      .imem_clock(im1), .dmem_clock(dm1), .processor_clock(pc1), .regfile_clock(rf1),
      .sys_reset(sr1), .locked(lk1), .proc_tick(tk1)
   );

   always #5 clock = ~clock;

   // reset at edges 1-3, then one-cycle reset at edge 50 while processor_clock is high
   function automatic logic r_at(input int e);
      return e <= 3 || e == 50;
   endfunction

   // stall held through HOLD of the first run, then only before edge 38 of the second run
   function automatic logic s_at(input int e);
`ifdef CLK_GEN_STALL_EN
      return e <= 35 || e == 88;
`else
      return (e < 0);
`endif
   endfunction

   // stimulus: drive inputs, model expected outputs per edge, push into scoreboard
   initial begin
      int         n [2];
      logic       pc [2];
      logic [6:0] x [2];
      logic       r, s, sk, srx, tkx, dmx;
      n  = '{0, 0};
      pc = '{1'b0, 1'b0};
      reset = r_at(1);
      stall = s_at(1);
      for (int e = 1; e <= E; e++) begin
         @(posedge clock);
         r = reset;
         s = stall;
         for (int i = 0; i < 2; i++) begin
            if (r) begin
               n[i]  = 0;
               pc[i] = 1'b0;
            end else begin
               sk = (i == 0) && s && n[i] >= pd[i] * hc[i];
               n[i]++;
               if (n[i] % pd[i] == pd[i] / 2 && !sk)
                  pc[i] = 1'b1;
               else if (n[i] % pd[i] == 0)
                  pc[i] = 1'b0;
            end
         end
         #1;
         reset = r_at(e + 1);
         stall = s_at(e + 1);
         for (int i = 0; i < 2; i++) begin
            srx  = n[i] < pd[i] * hc[i];
            dmx  = ((n[i] / (dd[i] / 2)) % 2) == 1;
            tkx  = !reset && ((n[i] + 1) % pd[i] == pd[i] / 2)
                   && !((i == 0) && stall && n[i] >= pd[i] * hc[i]);
            x[i] = {pc[i], pc[i], dmx, srx, !srx, tkx, 1'b0};
         end
         q.push_back('{e, x[0], x[1]});
      end
      done = 1'b1;
      repeat (6) @(negedge clock);
      if (!fin) begin
         $display("FAIL drain: scoreboard still holds %0d entries, required 0", q.size());
         $fatal(1, "scoreboard did not drain");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // monitor: imem high just after the rising edge, full vector compare at the falling edge
   always begin
      exp_t x;
      @(posedge clock);
      #2;
      checks++;
      if (im0 !== 1'b1 || im1 !== 1'b1) begin
         errors++;
         $display("FAIL imem_high: got %b%b, required 11", im0, im1);
      end
      @(negedge clock);
      if (q.size() > 0) begin
         x = q.pop_front();
         checks += 2;
         if ({pc0, rf0, dm0, sr0, lk0, tk0, im0} !== x.x0) begin
            errors++;
            $display("FAIL dut0 edge %0d: got pc,rf,dm,sr,lk,tk,im=%b, required %b", x.e,
                     {pc0, rf0, dm0, sr0, lk0, tk0, im0}, x.x0);
         end
         if ({pc1, rf1, dm1, sr1, lk1, tk1, im1} !== x.x1) begin
            errors++;
            $display("FAIL dut1 edge %0d: got pc,rf,dm,sr,lk,tk,im=%b, required %b", x.e,
                     {pc1, rf1, dm1, sr1, lk1, tk1, im1}, x.x1);
         end
         if (pc0 && !pv0 && sr0) rises0++;
         if (pc1 && !pv1 && sr1) rises1++;
         pv0 = pc0;
         pv1 = pc1;
      end else if (done && !fin) begin
         checks += 2;
         if (rises0 != 16) begin
            errors++;
            $display("FAIL hold_rises0: got %0d rises under sys_reset, required 16", rises0);
         end
         if (rises1 != 4) begin
            errors++;
            $display("FAIL hold_rises1: got %0d rises under sys_reset, required 4", rises1);
         end
         fin = 1'b1;
      end
   end
endmodule
